// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the pipeline memory stage.
//   - Funct3 access-size encodings
//   - memory-stage FSM state type
//   - access-size decode, byte-enable and misalignment helpers
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic { IDLE, WAIT } mem_state_t;

   typedef enum logic [1:0] { SZ_B, SZ_H, SZ_W } acc_size_t;

   // Unlisted encodings behave as full-word accesses.
   function automatic acc_size_t acc_size(input logic [2:0] funct3);
      acc_size_t sz;
      case (funct3)
         F3_B, F3_BU: sz = SZ_B;
         F3_H, F3_HU: sz = SZ_H;
         F3_W:        sz = SZ_W;
         default:     sz = SZ_W;
      endcase
      return sz;
   endfunction

   function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] off);
      logic [3:0] be;
      case (acc_size(funct3))
         SZ_B:    be = 4'b0001 << off;
         SZ_H:    be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
      logic m;
      case (acc_size(funct3))
         SZ_B:    m = 1'b0;
         SZ_H:    m = off[0];
         default: m = (off != 2'b00);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/dmem_be.sv
// dmem_be: word-organised data memory with per-byte write enables.
// Write is synchronous on the rising edge; read is combinational.
// Contents are never reset.
// Ports:
//   clk      - clock
//   i_we     - write strobe for this edge
//   i_be     - byte-lane enables (bit n covers bits 8n+7:8n)
//   i_addr   - word index
//   i_wdata  - lane-replicated write data
//   o_rdata  - word at i_addr
module dmem_be #(
   parameter int DEPTH_WORDS = 256,
   parameter int AW          = $clog2(DEPTH_WORDS)
)(
   input  logic          clk,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage_be.sv
// mem_stage_be: pipeline MEM stage with byte/halfword/word loads and stores,
// sign/zero extension, misalignment detection, configurable memory wait
// states and the MEM/WB pipeline register.
// Ports:
//   clk, reset (sync, active-low)
//   ALUResultM, WriteDataM, PCPlus4M, RdM, RegWriteM, MemWriteM, MemReadM,
//   Funct3M, ResultSrcM          - EX/MEM registered inputs, held while StallM
//   StallM                       - combinational upstream freeze
//   ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MisalignW
//                                - MEM/WB register outputs
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting a new instruction; single-cycle ops complete here
// WAIT  | memory wait states; r_cnt counts down, completion when r_cnt==0
module mem_stage_be
   import mem_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int MEM_LATENCY = 0
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [4:0]      RdM,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            MemReadM,
   input  logic [2:0]      Funct3M,
   input  logic [1:0]      ResultSrcM,
   output logic            StallM,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [4:0]      RdW,
   output logic            RegWriteW,
   output logic [1:0]      ResultSrcW,
   output logic            MisalignW
);

   localparam int         AW       = $clog2(DEPTH_WORDS);
   localparam logic [1:0] CNT_LOAD = (MEM_LATENCY > 0) ? 2'(MEM_LATENCY - 1) : 2'd0;

   if (XLEN != 32) begin : g_chk_xlen
      $error("mem_stage_be: XLEN must be 32");
   end
   if ((DEPTH_WORDS < 2) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_chk_depth
      $error("mem_stage_be: DEPTH_WORDS must be a power of two");
   end
   if ((MEM_LATENCY < 0) || (MEM_LATENCY > 3)) begin : g_chk_lat
      $error("mem_stage_be: MEM_LATENCY must be 0..3");
   end

   mem_state_t    r_state, w_state_nxt;
   logic [1:0]    r_cnt, w_cnt_nxt;
   logic          w_mem_op, w_misalign, w_slow;
   logic          w_stall, w_complete, w_we;
   logic [1:0]    w_off;
   acc_size_t     w_size;
   logic [3:0]    w_be;
   logic [AW-1:0] w_index;
   logic [31:0]   w_wdata, w_rword, w_load, w_rd_val;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic          w_unused;

   assign w_off      = ALUResultM[1:0];
   assign w_index    = ALUResultM[AW+1:2];
   assign w_size     = acc_size(Funct3M);
   assign w_be       = byte_en(Funct3M, w_off);
   assign w_mem_op   = MemWriteM | MemReadM;
   assign w_misalign = w_mem_op & misaligned(Funct3M, w_off);
   assign w_slow     = w_mem_op & ~w_misalign & (MEM_LATENCY != 0);

   // Address bits above the memory index are intentionally ignored (wrap).
   assign w_unused = ^ALUResultM[XLEN-1:AW+2];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // The first cycle of a slow access already stalls; the completion cycle
   // never does, so an L-wait access spends L+1 cycles in M with L stalls.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_stall     = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_slow) begin
               w_stall     = 1'b1;
               w_state_nxt = WAIT;
               w_cnt_nxt   = CNT_LOAD;
            end else begin
               w_complete = 1'b1;
            end
         end
         WAIT: begin
            if (r_cnt == 2'd0) begin
               w_complete  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_stall   = 1'b1;
               w_cnt_nxt = r_cnt - 2'd1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign StallM = w_stall & reset;

   // Gating with reset drops a store whose completion edge coincides with reset.
   assign w_we = w_complete & MemWriteM & ~w_misalign & reset;

   always_comb begin
      case (w_size)
         SZ_B:    w_wdata = {4{WriteDataM[7:0]}};
         SZ_H:    w_wdata = {2{WriteDataM[15:0]}};
         default: w_wdata = WriteDataM[31:0];
      endcase
   end

   dmem_be #(.DEPTH_WORDS(DEPTH_WORDS)) u_dmem (
      .clk     (clk),
      .i_we    (w_we),
      .i_be    (w_be),
      .i_addr  (w_index),
      .i_wdata (w_wdata),
      .o_rdata (w_rword)
   );

   assign w_byte = w_rword[{w_off, 3'b000} +: 8];
   assign w_half = w_rword[{w_off[1], 4'b0000} +: 16];

   always_comb begin
      case (Funct3M)
         F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
         F3_BU:   w_load = {24'b0, w_byte};
         F3_H:    w_load = {{16{w_half[15]}}, w_half};
         F3_HU:   w_load = {16'b0, w_half};
         default: w_load = w_rword;
      endcase
   end

   // Only an aligned pure load returns data; stores (including store+load) return 0.
   assign w_rd_val = (MemReadM & ~MemWriteM & ~w_misalign) ? w_load : 32'b0;

   always_ff @(posedge clk) begin
      if (!reset || w_stall) begin
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         MisalignW  <= 1'b0;
      end else begin
         ALUResultW <= ALUResultM;
         ReadDataW  <= w_rd_val;
         PCPlus4W   <= PCPlus4M;
         RdW        <= RdM;
         RegWriteW  <= RegWriteM & ~w_misalign;
         ResultSrcW <= ResultSrcM;
         MisalignW  <= w_misalign;
      end
   end

endmodule

// File: tb/tb_mem_stage_be.sv
// Bench for mem_stage_be: three instances (MEM_LATENCY 0, 2, 3) exercised one
// at a time. A byte-addressed reference memory predicts each result, which is
// queued at issue and checked by an independent monitor on W.
module tb_mem_stage_be;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic [2:0][31:0] alu_m, wd_m, pc_m;
   logic [2:0][4:0]  rd_m;
   logic [2:0]       rw_m, mw_m, mr_m;
   logic [2:0][2:0]  f3_m;
   logic [2:0][1:0]  rs_m;

   logic [2:0]       stall;
   logic [2:0][31:0] alu_w, rdat_w, pc_w;
   logic [2:0][4:0]  rd_w;
   logic [2:0]       rw_w, mis_w;
   logic [2:0][1:0]  rs_w;

   mem_stage_be #(.MEM_LATENCY(0)) u_dut0 (
      .clk(clk), .reset(reset), .ALUResultM(alu_m[0]), .WriteDataM(wd_m[0]), .PCPlus4M(pc_m[0]),
      .RdM(rd_m[0]), .RegWriteM(rw_m[0]), .MemWriteM(mw_m[0]), .MemReadM(mr_m[0]),
      .Funct3M(f3_m[0]), .ResultSrcM(rs_m[0]), .StallM(stall[0]), .ALUResultW(alu_w[0]),
      .ReadDataW(rdat_w[0]), .PCPlus4W(pc_w[0]), .RdW(rd_w[0]), .RegWriteW(rw_w[0]),
      .ResultSrcW(rs_w[0]), .MisalignW(mis_w[0]));

   mem_stage_be #(.MEM_LATENCY(2)) u_dut1 (
      .clk(clk), .reset(reset), .ALUResultM(alu_m[1]), .WriteDataM(wd_m[1]), .PCPlus4M(pc_m[1]),
      .RdM(rd_m[1]), .RegWriteM(rw_m[1]), .MemWriteM(mw_m[1]), .MemReadM(mr_m[1]),
      .Funct3M(f3_m[1]), .ResultSrcM(rs_m[1]), .StallM(stall[1]), .ALUResultW(alu_w[1]),
      .ReadDataW(rdat_w[1]), .PCPlus4W(pc_w[1]), .RdW(rd_w[1]), .RegWriteW(rw_w[1]),
      .ResultSrcW(rs_w[1]), .MisalignW(mis_w[1]));

   mem_stage_be #(.MEM_LATENCY(3)) u_dut2 (
      .clk(clk), .reset(reset), .ALUResultM(alu_m[2]), .WriteDataM(wd_m[2]), .PCPlus4M(pc_m[2]),
      .RdM(rd_m[2]), .RegWriteM(rw_m[2]), .MemWriteM(mw_m[2]), .MemReadM(mr_m[2]),
      .Funct3M(f3_m[2]), .ResultSrcM(rs_m[2]), .StallM(stall[2]), .ALUResultW(alu_w[2]),
      .ReadDataW(rdat_w[2]), .PCPlus4W(pc_w[2]), .RdW(rd_w[2]), .RegWriteW(rw_w[2]),
      .ResultSrcW(rs_w[2]), .MisalignW(mis_w[2]));

   typedef struct {
      int          dut;
      logic [31:0] alu;
      logic [31:0] rdat;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rw;
      logic [1:0]  rs;
      logic        mis;
      bit          chk_rd;
   } exp_t;

   exp_t        sbq[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [7:0]  mm [3][1024];
   logic [2:0]  stall_e = 3'b000;

   function automatic int lat(input int k);
      return (k == 0) ? 0 : (k == 1) ? 2 : 3;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic clear_in(input int k);
      alu_m[k] = '0; wd_m[k] = '0; pc_m[k] = '0; rd_m[k] = '0;
      rw_m[k] = 1'b0; mw_m[k] = 1'b0; mr_m[k] = 1'b0; f3_m[k] = '0; rs_m[k] = '0;
   endtask

   // Called at a falling edge; returns at the falling edge after the result is in W.
   task automatic issue(input int k, input logic wr, input logic rd, input logic rw,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rdst, input bit use_lit, input logic [31:0] lit);
      exp_t        e;
      int          sz, nst;
      bit          mis;
      logic [31:0] val, pc;
      logic [9:0]  ba;
      logic [1:0]  rs;
      pc = ($urandom & 32'hFFFF_FFFC) | 32'h4;
      rs = 2'($urandom_range(0, 3));
      alu_m[k] = addr; wd_m[k] = wd; pc_m[k] = pc; rd_m[k] = rdst; rw_m[k] = rw;
      mw_m[k] = wr; mr_m[k] = rd; f3_m[k] = f3; rs_m[k] = rs;

      sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      mis = (wr || rd) && ((int'(addr[1:0]) % sz) != 0);
      ba  = addr[9:0];
      if (wr && !mis)
         for (int b = 0; b < sz; b++) mm[k][ba + 10'(b)] = 8'(wd >> (8 * b));
      val = 32'h0;
      if (rd && !wr && !mis) begin
         for (int b = 0; b < sz; b++) val = val | (32'(mm[k][ba + 10'(b)]) << (8 * b));
         if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
         if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      end
      e.dut = k; e.alu = addr; e.pc = pc; e.rd = rdst; e.rw = rw && !mis;
      e.rs = rs; e.mis = mis; e.rdat = use_lit ? lit : val; e.chk_rd = mis || (rd && !wr);
      sbq.push_back(e);

      nst = 0;
      #1;
      while (stall[k] === 1'b1 && nst < 8) begin
         @(negedge clk);
         #1;
         nst++;
      end
      check($sformatf("stall_cycles_dut%0d", k), 32'(nst), ((wr || rd) && !mis) ? 32'(lat(k)) : 32'd0);
      @(negedge clk);
   endtask

   always @(posedge clk) stall_e <= stall;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] r_exp;
      for (int k = 0; k < 3; k++) begin
         if (stall_e[k]) begin
            n_total++;
            if ({alu_w[k], rdat_w[k], pc_w[k], rd_w[k], rw_w[k], rs_w[k], mis_w[k]} === '0) n_pass++;
            else $display("FAIL bubble_dut%0d: got alu=%h rdat=%h pc=%h rw=%b want all zero",
                          k, alu_w[k], rdat_w[k], pc_w[k], rw_w[k]);
         end else if (pc_w[k] != 32'h0) begin
            n_total++;
            if (sbq.size() == 0) begin
               $display("FAIL wb_dut%0d: got unexpected result pc=%h want none", k, pc_w[k]);
            end else begin
               e = sbq.pop_front();
               r_exp = e.chk_rd ? e.rdat : rdat_w[k];
               if (e.dut == k &&
                   {alu_w[k], rdat_w[k], pc_w[k], rd_w[k], rw_w[k], rs_w[k], mis_w[k]} ===
                   {e.alu, r_exp, e.pc, e.rd, e.rw, e.rs, e.mis})
                  n_pass++;
               else
                  $display("FAIL wb_dut%0d: got alu=%h rdat=%h pc=%h rd=%0d rw=%b rs=%0d mis=%b want dut%0d alu=%h rdat=%h pc=%h rd=%0d rw=%b rs=%0d mis=%b",
                           k, alu_w[k], rdat_w[k], pc_w[k], rd_w[k], rw_w[k], rs_w[k], mis_w[k],
                           e.dut, e.alu, r_exp, e.pc, e.rd, e.rw, e.rs, e.mis);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      int          t;
      logic        wr, rd;

      reset = 1'b0;
      for (int k = 0; k < 3; k++) clear_in(k);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_w_dut%0d", k),
               alu_w[k] | rdat_w[k] | pc_w[k] | 32'({rd_w[k], rw_w[k], rs_w[k], mis_w[k]}), 32'h0);
         check($sformatf("reset_stall_dut%0d", k), 32'(stall[k]), 32'h0);
      end
      reset = 1'b1;

      // Fill the exercised region (words 0..15) with known data.
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < 16; w++) issue(k, 1, 0, 0, 3'b010, 32'(w * 4), $urandom, 5'd0, 0, 0);
         clear_in(k);
      end

      // Latency 0 directed sequence.
      issue(0, 1, 0, 0, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, 0, 0);
      issue(0, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd2, 1, 32'hDEADBEEF);
      issue(0, 0, 1, 1, 3'b000, 32'h13, 32'h0, 5'd3, 1, 32'hFFFFFFDE);
      issue(0, 0, 1, 1, 3'b100, 32'h13, 32'h0, 5'd4, 1, 32'h000000DE);
      issue(0, 0, 1, 1, 3'b001, 32'h12, 32'h0, 5'd5, 1, 32'hFFFFDEAD);
      issue(0, 1, 0, 0, 3'b000, 32'h11, 32'hAABBCC55, 5'd6, 0, 0);
      issue(0, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd7, 1, 32'hDEAD55EF);
      issue(0, 0, 1, 1, 3'b010, 32'h12, 32'h0, 5'd8, 1, 32'h0);
      issue(0, 1, 0, 1, 3'b010, 32'h12, 32'h01020304, 5'd9, 0, 0);
      issue(0, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd10, 1, 32'hDEAD55EF);
      clear_in(0);

      // Latency 2: load with bubbles and destination tracking.
      issue(1, 1, 0, 0, 3'b010, 32'h10, 32'hCAFEF00D, 5'd0, 0, 0);
      issue(1, 0, 1, 1, 3'b010, 32'h10, 32'h0, 5'd7, 1, 32'hCAFEF00D);
      clear_in(1);

      // Randomized traffic on every latency; upper address bits exercise wrap.
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 150; i++) begin
            t  = int'($urandom_range(0, 9));
            wr = (t < 3) || (t == 9);
            rd = (t >= 3 && t < 7) || (t == 9);
            a  = $urandom;
            if (wr || rd) a[9:6] = 4'b0000;
            issue(k, wr, rd, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                  5'($urandom_range(0, 31)), 0, 0);
         end
         clear_in(k);
      end

      // Latency 3: reset during the second stall cycle aborts the store.
      alu_m[2] = 32'h20; wd_m[2] = 32'h12345678; pc_m[2] = 32'h104; rd_m[2] = 5'd3;
      mw_m[2] = 1'b1; f3_m[2] = 3'b010;
      #1;
      check("abort_stall_c0", 32'(stall[2]), 32'h1);
      @(negedge clk);
      #1;
      check("abort_stall_c1", 32'(stall[2]), 32'h1);
      reset = 1'b0;
      #1;
      check("stall_during_reset", 32'(stall[2]), 32'h0);
      @(negedge clk);
      check("abort_w_cleared",
            alu_w[2] | rdat_w[2] | pc_w[2] | 32'({rd_w[2], rw_w[2], rs_w[2], mis_w[2]}), 32'h0);
      check("abort_stall_after", 32'(stall[2]), 32'h0);
      clear_in(2);
      reset = 1'b1;
      @(negedge clk);
      issue(2, 0, 1, 1, 3'b010, 32'h20, 32'h0, 5'd11, 0, 0);
      clear_in(2);

      repeat (4) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_stage_be.md
# mem_stage_be

Parametrised pipeline memory stage for the RISC-V core, the successor to the single-cycle word-only MEM stage. It takes EX/MEM-registered signals and performs byte/halfword/word loads and stores with sign/zero extension and misalignment detection. A data memory with configurable wait states stalls the upstream pipeline while an access completes. The block registers results into the MEM/WB register, which feeds writeback.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 only in this generation, checked by elaboration assertion.
- `DEPTH_WORDS`, 256: data memory depth in words; must be a power of two.
- `MEM_LATENCY`, 0: wait states per load/store, 0..3. A value of 0 gives single-cycle behaviour.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `reset`, in, 1: synchronous, active-low. Sampled on the `clk` rising edge; `reset`=0 resets.
- `ALUResultM`, in, XLEN: effective address, or the ALU result for non-memory instructions.
- `WriteDataM`, in, XLEN: store data, right-aligned.
- `PCPlus4M`, in, XLEN: passthrough.
- `RdM`, in, 5: destination register.
- `RegWriteM`, `MemWriteM`, `MemReadM`, in, 1: control.
- `Funct3M`, in, 3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
- `ResultSrcM`, in, 2: passthrough.
- `StallM`, out, 1: combinational. Upstream must freeze and hold all M inputs stable while it is 1.
- `ALUResultW`, `ReadDataW`, `PCPlus4W`, out, XLEN: MEM/WB register outputs.
- `RdW`, out, 5: MEM/WB register output.
- `RegWriteW`, out, 1: MEM/WB register output.
- `ResultSrcW`, out, 2: MEM/WB register output.
- `MisalignW`, out, 1: registered exception flag for the instruction now in W.

## Operation
- An access is any cycle in IDLE with `MemWriteM`|`MemReadM`=1. If both are asserted, the store wins and `RegWriteW` follows `RegWriteM`.
- Word index is `ALUResultM[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the memory size.
- Misalignment rules:
  - H/HU with `addr[0]`=1 is misaligned.
  - W with `addr[1:0]`≠0 is misaligned.
  - A misaligned access never writes memory, never stalls, and produces `MisalignW`=1, `RegWriteW`=0, `ReadDataW`=0.
- Store byte enables:
  - B: `4'b0001<<addr[1:0]`.
  - H: `4'b0011<<addr[1:0]`.
  - W: `4'b1111`.
  - Write data is replicated across lanes.
- Loads select the byte or halfword lane by `addr[1:0]`.
  - B and H sign-extend; BU and HU zero-extend; W passes the word through.
  - Any other `Funct3M` value is treated as W.
- FSM states:
  - IDLE: on an aligned access with `MEM_LATENCY`>0, go to WAIT with `cnt`=`MEM_LATENCY`-1. Otherwise complete in the same cycle.
  - WAIT: `StallM`=1. Decrement `cnt`. When `cnt`=0, go to IDLE; this is the completion cycle.
- The memory write is performed exactly once, at the completion clock edge. Read data is sampled at completion.
- While `StallM`=1, the MEM/WB register loads a bubble: all outputs zero.
- Memory contents are not reset.

## Timing
- Reset (`reset`=0 at an edge) clears all W outputs to 0, returns the FSM to IDLE, and clears `cnt` to 0.
- `StallM` is 0 during and after reset.
- A reset mid-WAIT aborts the access, and a pending store is dropped with no write.
- With `MEM_LATENCY`=L, an aligned load/store occupies L+1 cycles in M:
  - `StallM` is high for cycles 0..L-1 of the access.
  - W shows L bubbles, then the result.
- Non-memory instructions and misaligned accesses take 1 cycle with no stall.
- The M→W latency is always one edge after completion.
- A load immediately following a store to the same word, in back-to-back cycles, returns the stored data. This is write-first at the completion edge, so no forwarding is required.

## Structure
- Shared package `mem_pkg` holds:
  - localparams for the Funct3 encodings (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the FSM state enum `mem_state_t` {IDLE, WAIT};
  - a function computing byte enables.
- Sub-module `dmem_be` is a byte-enable synchronous-write, combinational-read array, parameterised by `DEPTH_WORDS`.
- The MEM/WB register, FSM, alignment logic and extension logic live in the top of this block.

## Test plan
- `MEM_LATENCY`=0:
  - SW 0xDEADBEEF at 0x10, then LW 0x10 → `ReadDataW`=0xDEADBEEF one edge later.
  - `StallM` stays 0 throughout.
- Byte load extension, after the SW above: LB at 0x13 → 0xFFFFFFDE; LBU at 0x13 → 0x000000DE; LH at 0x12 → 0xFFFFDEAD.
- SB 0x55 at 0x11 over 0xDEADBEEF, then LW 0x10 → 0xDEAD55EF.
- Misaligned LW at 0x12 → `MisalignW`=1, `RegWriteW`=0, no stall, and memory unchanged.
- `MEM_LATENCY`=2, LW:
  - `StallM`=1 for exactly 2 cycles.
  - W shows 2 bubbles (`RegWriteW`=0), then valid data with `RdW` correct.
- `MEM_LATENCY`=3, SW 0x12345678 to 0x20, with `reset`=0 asserted in the second stall cycle:
  - All W outputs are 0 on the next edge.
  - A later LW 0x20 returns the old contents.
